switch_debouncer: RTL and testbench

- Input-conditioning stage placed directly upstream of the priority-encoder/7-segment display block.
- Synchronises WIDTH raw, bouncing switch inputs to clk and debounces each bit independently.
- Presents clean, stable levels on data, which drives the encoder's data inputs, plus one-cycle rise pulses per bit.

---
 rtl/switch_debouncer_pkg.sv | 13 +
 rtl/switch_debouncer_debounce_bit.sv | 47 ++++
 rtl/switch_debouncer.sv | 55 +++++
 tb/tb_switch_debouncer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared defaults and the counter-width helper for the switch debouncer.
package switch_debouncer_pkg;

  localparam int DEFAULT_WIDTH           = 8;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  // Wide enough to hold DEBOUNCE_CYCLES, although the count never gets past DEBOUNCE_CYCLES-1.
  function automatic int cnt_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch channel: synchroniser chain, persistence counter, stable level
// and a registered pulse on each accepted 0->1 change.
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic stable,
  output logic rise
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sw};
      rise <= 1'b0;
      if (s == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Acceptance edge: rise goes high in the same cycle that stable shows the new 1.
        stable <= s;
        cnt    <= '0;
        rise   <= s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// WIDTH-channel switch debouncer feeding the priority encoder.
// Optional STICKY_LATCH_EN holds every pressed bit in data until clear.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             clear,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] rise,
  output logic             any
);

  logic [WIDTH-1:0] stable;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .sw    (sw_in[i]),
      .stable(stable[i]),
      .rise  (rise[i])
    );
  end

`ifdef STICKY_LATCH_EN
  logic [WIDTH-1:0] sticky;

  // A rise arriving with clear still sets its bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky <= '0;
    end else begin
      sticky <= (sticky & ~{WIDTH{clear}}) | rise;
    end
  end

  assign data = stable | sticky;
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign data = stable;
`endif

  assign any = |data;

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised and directed bench for switch_debouncer against a sample-window model.
module tb_switch_debouncer;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int DC    = 4;
  localparam int HD    = SYNC - 1 + DC;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sw_in;
  logic             clear;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] rise;
  logic             any;

  int n_pass  = 0;
  int n_total = 0;

  switch_debouncer #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DC)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .sw_in(sw_in),
    .clear(clear),
    .data (data),
    .rise (rise),
    .any  (any)
  );

  always #5 clk = ~clk;

  // Reference: hist[k] is sw_in as sampled k+1 edges ago. A bit flips when the
  // last DC synchronised samples all agree and differ from the current level.
  logic [WIDTH-1:0] hist [HD];
  logic [WIDTH-1:0] m_stable, m_rise, m_sticky, m_data;

  always @(posedge clk or posedge rst) begin : model
    logic [WIDTH-1:0] nr;
    bit same;
    if (rst) begin
      for (int k = 0; k < HD; k++) hist[k] = '0;
      m_stable = '0;
      m_rise   = '0;
      m_sticky = '0;
    end else begin
      nr = '0;
      for (int b = 0; b < WIDTH; b++) begin
        same = 1'b1;
        for (int k = SYNC - 1; k < HD; k++)
          if (hist[k][b] !== hist[SYNC-1][b]) same = 1'b0;
        if (same && (hist[SYNC-1][b] !== m_stable[b])) begin
          m_stable[b] = hist[SYNC-1][b];
          nr[b]       = hist[SYNC-1][b];
        end
      end
      m_sticky = (m_sticky & ~{WIDTH{clear}}) | m_rise;
      m_rise   = nr;
      for (int k = HD - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = sw_in;
    end
  end

`ifdef STICKY_LATCH_EN
  assign m_data = m_stable | m_sticky;
`else
  assign m_data = m_stable;
`endif

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sw_in = 8'hFF; clear = 1'b0;
    repeat (3) step();
    n_total++; if (data !== 8'h00) $display("FAIL reset_data: got %h expected 00", data); else n_pass++;
    n_total++; if (rise !== 8'h00) $display("FAIL reset_rise: got %h expected 00", rise); else n_pass++;
    n_total++; if (any !== 1'b0) $display("FAIL reset_any: got %b expected 0", any); else n_pass++;
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      n_total++;
      if (data !== ((e >= 6) ? 8'hFF : 8'h00))
        $display("FAIL release_data edge %0d: got %h expected %h", e, data, (e >= 6) ? 8'hFF : 8'h00);
      else n_pass++;
      n_total++;
      if (rise !== ((e == 6) ? 8'hFF : 8'h00))
        $display("FAIL release_rise edge %0d: got %h expected %h", e, rise, (e == 6) ? 8'hFF : 8'h00);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    sw_in = 8'h00;
    repeat (8) step();
    n_total++; if (data !== 8'h00) $display("FAIL glitch_pre: got %h expected 00", data); else n_pass++;
    sw_in = 8'h08;
    repeat (3) step();
    sw_in = 8'h00;
    for (int e = 0; e < 12; e++) begin
      step();
      n_total++;
      if (data !== 8'h00 || rise !== 8'h00)
        $display("FAIL glitch cycle %0d: got data %h rise %h expected 00 00", e, data, rise);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    sw_in = 8'h80; step();
    if (rise[7]) pulses++;
    sw_in = 8'h00; step();
    if (rise[7]) pulses++;
    sw_in = 8'h80; step();
    if (rise[7]) pulses++;
    sw_in = 8'h00; step();
    if (rise[7]) pulses++;
    sw_in = 8'h80;
    for (int e = 1; e <= 9; e++) begin
      step();
      if (rise[7]) pulses++;
      n_total++;
      if (data !== ((e >= 6) ? 8'h80 : 8'h00))
        $display("FAIL bounce_data edge %0d: got %h expected %h", e, data, (e >= 6) ? 8'h80 : 8'h00);
      else n_pass++;
      n_total++;
      if (rise !== ((e == 6) ? 8'h80 : 8'h00))
        $display("FAIL bounce_rise edge %0d: got %h expected %h", e, rise, (e == 6) ? 8'h80 : 8'h00);
      else n_pass++;
    end
    n_total++; if (pulses != 1) $display("FAIL bounce_pulses: got %0d expected 1", pulses); else n_pass++;
  endtask

  task automatic test_release();
    sw_in = 8'h00;
    for (int e = 1; e <= 8; e++) begin
      step();
      n_total++;
      if (data !== ((e >= 6) ? 8'h00 : 8'h80) || rise !== 8'h00 || any !== (e < 6))
        $display("FAIL release edge %0d: got data %h rise %h any %b expected %h 00 %b",
                 e, data, rise, any, (e >= 6) ? 8'h00 : 8'h80, e < 6);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    sw_in = 8'h01;
    repeat (8) step();
    n_total++; if (data !== 8'h01) $display("FAIL areset_pre: got %h expected 01", data); else n_pass++;
    sw_in = 8'h05;
    repeat (4) step();
    n_total++;
    if (u_dut.g_bit[2].u_bit.cnt !== 3'd2)
      $display("FAIL areset_cnt_pre: got %0d expected 2", u_dut.g_bit[2].u_bit.cnt);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (data !== 8'h00 || rise !== 8'h00 || any !== 1'b0)
      $display("FAIL areset_immediate: got data %h rise %h any %b expected 00 00 0", data, rise, any);
    else n_pass++;
    n_total++;
    if (u_dut.g_bit[2].u_bit.cnt !== 3'd0)
      $display("FAIL areset_cnt: got %0d expected 0", u_dut.g_bit[2].u_bit.cnt);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      n_total++;
      if (data !== ((e >= 6) ? 8'h05 : 8'h00))
        $display("FAIL areset_recover edge %0d: got %h expected %h", e, data, (e >= 6) ? 8'h05 : 8'h00);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < WIDTH; b++)
        if ($urandom_range(0, 5) == 0) sw_in[b] = ~sw_in[b];
      clear = ($urandom_range(0, 15) == 0);
      step();
      n_total++;
      if (data !== m_data || rise !== m_rise || any !== (|m_data)) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random cycle %0d: got data %h rise %h any %b expected %h %h %b",
                   c, data, rise, any, m_data, m_rise, |m_data);
      end else n_pass++;
    end
    clear = 1'b0;
  endtask

`ifdef STICKY_LATCH_EN
  task automatic test_sticky();
    bit seen = 1'b0;
    sw_in = 8'h00;
    repeat (8) step();
    clear = 1'b1; step(); clear = 1'b0;
    step();
    n_total++; if (data !== 8'h00) $display("FAIL sticky_start: got %h expected 00", data); else n_pass++;
    sw_in = 8'h20; repeat (8) step();
    sw_in = 8'h00; repeat (8) step();
    n_total++; if (data !== 8'h20) $display("FAIL sticky_hold: got %h expected 20", data); else n_pass++;
    clear = 1'b1; step(); clear = 1'b0;
    n_total++; if (data !== 8'h00) $display("FAIL sticky_clear: got %h expected 00", data); else n_pass++;
    sw_in = 8'h10;
    for (int e = 0; e < 10 && !seen; e++) begin
      step();
      if (rise[4]) seen = 1'b1;
    end
    n_total++; if (!seen) $display("FAIL sticky_rise_timeout: got no rise expected rise[4]"); else n_pass++;
    clear = 1'b1; step(); clear = 1'b0;
    sw_in = 8'h00; repeat (8) step();
    n_total++; if (data !== 8'h10) $display("FAIL sticky_set_wins: got %h expected 10", data); else n_pass++;
  endtask
`else
  task automatic test_clear_ignored();
    sw_in = 8'h20; repeat (8) step();
    clear = 1'b1; step(); clear = 1'b0;
    n_total++; if (data !== 8'h20) $display("FAIL clear_held: got %h expected 20", data); else n_pass++;
    sw_in = 8'h00; repeat (8) step();
    n_total++; if (data !== 8'h00) $display("FAIL no_sticky: got %h expected 00", data); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_bounce();
    test_release();
    test_async_reset();
    test_random();
`ifdef STICKY_LATCH_EN
    test_sticky();
`else
    test_clear_ignored();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
